fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and decode in the LEGv8 pipeline.
- Captures (PC, instruction) pairs from fetch/imem and presents them in order to decode with a valid/ready handshake.
- Decouples decode stalls from fetch.
- Flushed when a taken branch (PCSrc) redirects fetch.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
IW, 32, instruction width in bits
AW, 64, PC width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
valid_F  in  1  fetch presents a valid PC/instruction pair this cycle
pc_F  in  AW  PC of the fetched instruction (imem_addr from fetch)
instr_F  in  IW  instruction word read from imem
ready_F  out  1  queue can accept an entry this cycle
flush_D  in  1  taken branch / redirect (PCSrc); discard all queued entries
valid_D  out  1  head entry valid for decode
pc_D  out  AW  PC of the head entry
instr_D  out  IW  instruction of the head entry
ready_D  in  1  decode accepts the head entry this cycle
count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (reset=1 at a rising edge):
  - count=0, read and write pointers=0.
  - valid_D=0, pc_D=0, instr_D=0, ready_F=1 after the edge.
  - Reset overrides push, pop and flush in the same cycle.
- Circular buffer with a read pointer and a write pointer, each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - count distinguishes full from empty.
- ready_F = (count < DEPTH). Combinational from state only; never depends on ready_D (no pass-through when full).
- Push occurs when valid_F && ready_F && !flush_D.
  - Writes {pc_F, instr_F} at wptr; wptr+1.
  - valid_F while ready_F=0: input ignored, no state change. Fetch must hold its PC.
- Pop occurs when valid_D && ready_D && !flush_D. rptr+1.
- Head outputs are show-ahead, driven combinationally from the entry at rptr:
  - valid_D = (count != 0).
  - When count==0: pc_D=0, instr_D=0.
- Latency: an entry pushed at edge N is visible on valid_D/pc_D/instr_D after edge N (1-cycle fill latency).
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged (legal for 0 < count < DEPTH).
  - neither: unchanged.
- Flush (flush_D=1, reset=0):
  - Next edge: count=0, rptr=wptr=0.
  - The concurrent push and pop are both discarded.
  - valid_D=0 in the following cycle.
  - Flush on an empty queue is a no-op apart from the pointer clear.
- Full: count==DEPTH, ready_F=0. A pop in that cycle frees a slot for the next cycle only.
- Empty: count==0, valid_D=0. ready_D is ignored.
- Ordering: strict FIFO. No entry is duplicated or dropped except by flush or reset.
- Reset asserted mid-stream discards all entries exactly like flush and additionally zeroes the outputs.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when count==0, valid_F=1, ready_D=1 and flush_D=0, the input pair is forwarded combinationally.
  - valid_D=1, pc_D=pc_F, instr_D=instr_F in the same cycle.
  - Not stored; count stays 0.
  - Zero-cycle latency when decode is free.
  - valid_D is also asserted combinationally whenever count==0 and valid_F=1.
- Undefined: no combinational path from the F-side inputs to the D-side outputs. Minimum latency is 1 cycle, as above.

Test Plan:
- Reset: hold reset=1 for 5 cycles with valid_F=1 -> count=0, valid_D=0, pc_D=0, instr_D=0, ready_F=1.
- Fill/drain: ready_D=0; push PCs 0,4,8,12 (instr 0xF8400020+i).
  - count=4, ready_F=0; a 5th push with PC 16 is ignored.
  - Then ready_D=1 -> outputs PCs 0,4,8,12 in order, one per cycle, then valid_D=0.
- Simultaneous push/pop: preload 2 entries, then push and pop every cycle for 10 cycles -> count stays 2; output PCs lag input by 2 entries; pointers wrap correctly.
- Flush: queue holds PCs 0,4,8; assert flush_D with valid_F=1 (PC 12) and ready_D=1.
  - Next cycle: count=0, valid_D=0.
  - Then push PC 40 -> head pc_D=40.
- Reset mid-operation: 3 entries queued; assert reset for 1 cycle -> count=0, outputs zero. A subsequent push of PC 100 appears at the head.
- Bypass (run with and without FETCH_QUEUE_BYPASS_EN): empty queue, ready_D=1, push PC 10 at edge N.
  - With the macro: pc_D=10 in the same cycle and count stays 0.
  - Without it: pc_D=10 after edge N and it is consumed at edge N+1.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction queue between the LEGv8 fetch stage and decode. Fetch pushes
// (PC, instruction) pairs with a valid/ready handshake. Decode sees the oldest
// pair show-ahead on valid_D/pc_D/instr_D and consumes it with ready_D.
// A taken branch (flush_D) discards everything queued.
//
// Storage is a circular buffer with read/write pointers. A separate occupancy
// count tells full from empty when the two pointers are equal.
//
// Configuration macro:
//   FETCH_QUEUE_BYPASS_EN - when defined, a pair presented to an empty queue
//                           is forwarded combinationally to decode. If decode
//                           is ready it is consumed without being stored.
//                           When undefined there is no combinational path from
//                           the fetch-side inputs to the decode-side outputs.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,   // number of entries, power of two, >= 2
  parameter int IW    = 32,  // instruction width
  parameter int AW    = 64   // PC width
) (
  input  logic                     clk,
  input  logic                     reset,

  // Fetch side
  input  logic                     valid_F,
  input  logic [AW-1:0]            pc_F,
  input  logic [IW-1:0]            instr_F,
  output logic                     ready_F,

  // Redirect from a taken branch
  input  logic                     flush_D,

  // Decode side
  output logic                     valid_D,
  output logic [AW-1:0]            pc_D,
  output logic [IW-1:0]            instr_D,
  input  logic                     ready_D,

  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [AW-1:0]    pc_mem    [DEPTH];
  logic [IW-1:0]    instr_mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count_q;

  logic empty;
  logic full;
  logic bypass_take;  // input pair consumed straight from fetch, never stored
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // count never exceeds DEPTH, so "not full" is the same as count < DEPTH.
  // ready_F comes from state only, so a pop in a full cycle does not
  // let a push through in that same cycle.
  assign ready_F = !full;
  assign count   = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue with decode ready hands the fetch pair straight through.
  assign bypass_take = empty && valid_F && ready_D && !flush_D;
`else
  assign bypass_take = 1'b0;
`endif

  // A bypassed pair is already consumed by decode, so it must not be stored.
  assign push = valid_F && ready_F && !flush_D && !bypass_take;

  // Only stored entries advance the read pointer. A bypassed pair never
  // occupies a slot, so it does not count as a pop.
  assign pop  = !empty && ready_D && !flush_D;

  // -------------------------------------------------------------------------
  // Head presentation: show-ahead from the entry at rptr, zeros when empty
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    valid_D = 1'b0;
    pc_D    = '0;
    instr_D = '0;
    if (!empty) begin
      valid_D = 1'b1;
      pc_D    = pc_mem[rptr];
      instr_D = instr_mem[rptr];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (valid_F) begin
      valid_D = 1'b1;
      pc_D    = pc_F;
      instr_D = instr_F;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Entry storage: write the incoming pair at wptr on a push
  // -------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset. The pointers and count
  // decide which slots are live, and the head outputs are forced to zero while
  // the queue is empty. A reset here would only add a reset fan-out to every
  // storage bit.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wptr]    <= pc_F;
      instr_mem[wptr] <= instr_F;
    end
  end

  // -------------------------------------------------------------------------
  // Pointer and occupancy register: reset, then flush, then push/pop
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the edge, independent of the order
  // of the statements.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr    <= '0;
      wptr    <= '0;
      count_q <= '0;
    end else if (flush_D) begin
      // Redirect: drop queued entries and any concurrent push/pop.
      rptr    <= '0;
      wptr    <= '0;
      count_q <= '0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two,
      // so the increment wraps modulo DEPTH by itself.
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;  // both or neither: occupancy unchanged
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue with default parameters (DEPTH=4, IW=32,
// AW=64). A table of one-cycle vectors covers reset, fill/drain, concurrent
// push/pop with pointer wrap, full behaviour, flush and reset mid-stream.
// Each vector drives its inputs for one rising edge. The inputs then return
// to idle, and the state-derived outputs are compared. A hand-written
// sequence then covers the same-cycle behaviour around the optional bypass
// (FETCH_QUEUE_BYPASS_EN).
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int AW    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_F;
  logic [AW-1:0] pc_F;
  logic [IW-1:0] instr_F;
  logic          ready_F;
  logic          flush_D;
  logic          valid_D;
  logic [AW-1:0] pc_D;
  logic [IW-1:0] instr_D;
  logic          ready_D;
  logic [CW-1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_F (valid_F),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .ready_F (ready_F),
    .flush_D (flush_D),
    .valid_D (valid_D),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .ready_D (ready_D),
    .count   (count)
  );

  always #5 clk = ~clk;

  // Stops a stalled run with a FAIL line if the clock or sequencing breaks.
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string         name;
    logic          rst;
    logic          vf;
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
    logic          fl;
    logic          rd;
    logic [CW-1:0] e_count;
    logic          e_valid;
    logic [AW-1:0] e_pc;
    logic [IW-1:0] e_ins;
    logic          e_ready_f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_v(input string name, input logic rst, input logic vf,
                       input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                       input logic fl, input logic rd,
                       input logic [CW-1:0] ec, input logic ev,
                       input logic [AW-1:0] epc, input logic [IW-1:0] eins,
                       input logic erf);
    vec_t v;
    v.name = name; v.rst = rst; v.vf = vf; v.pc = pc; v.ins = ins;
    v.fl = fl; v.rd = rd; v.e_count = ec; v.e_valid = ev; v.e_pc = epc;
    v.e_ins = eins; v.e_ready_f = erf;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    reset   = 1'b0;
    valid_F = 1'b0;
    pc_F    = '0;
    instr_F = '0;
    flush_D = 1'b0;
    ready_D = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [CW-1:0] ec, input logic ev,
                               input logic [AW-1:0] epc, input logic [IW-1:0] eins,
                               input logic erf);
    check({tag, ".count"},   64'(count),   64'(ec));
    check({tag, ".valid_D"}, 64'(valid_D), 64'(ev));
    check({tag, ".pc_D"},    pc_D,         epc);
    check({tag, ".instr_D"}, 64'(instr_D), 64'(eins));
    check({tag, ".ready_F"}, 64'(ready_F), 64'(erf));
  endtask

  localparam logic [IW-1:0] LDUR = 32'hF840_0020;
  localparam logic [IW-1:0] SEQI = 32'hA000_0000;

  initial begin
    idle_inputs();

    // ---------------- vector table ----------------
    // Reset held 5 cycles with fetch active.
    for (int i = 0; i < 5; i++)
      add_v($sformatf("reset%0d", i), 1, 1, 64'h44, 32'h1234, 0, 0, 0, 0, 0, 0, 1);

    // Fill with decode stalled; head stays at PC 0.
    for (int i = 0; i < 4; i++)
      add_v($sformatf("fill%0d", i), 0, 1, 64'(4*i), LDUR + 32'(i), 0, 0,
            CW'(i+1), 1, 64'h0, LDUR, (i < 3));
    add_v("push_when_full", 0, 1, 64'd16, 32'hDEAD, 0, 0, 4, 1, 64'h0, LDUR, 0);

    // Drain in order.
    for (int i = 1; i < 4; i++)
      add_v($sformatf("drain%0d", i), 0, 0, 0, 0, 0, 1,
            CW'(4-i), 1, 64'(4*i), LDUR + 32'(i), 1);
    add_v("drain_last", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    add_v("pop_empty",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Preload two, then push+pop for 10 cycles (pointers wrap 3 times).
    add_v("pre0", 0, 1, 64'h100, SEQI,     0, 0, 1, 1, 64'h100, SEQI, 1);
    add_v("pre1", 0, 1, 64'h104, SEQI + 1, 0, 0, 2, 1, 64'h100, SEQI, 1);
    for (int k = 0; k < 10; k++)
      add_v($sformatf("pushpop%0d", k), 0, 1, 64'(256 + 4*(k+2)), SEQI + 32'(k+2), 0, 1,
            2, 1, 64'(256 + 4*(k+1)), SEQI + 32'(k+1), 1);

    // Fill to full (head e10), then a pop while full frees a slot but the
    // offered push is refused in that cycle.
    add_v("fill_e12", 0, 1, 64'h130, SEQI + 12, 0, 0, 3, 1, 64'h128, SEQI + 10, 1);
    add_v("fill_e13", 0, 1, 64'h134, SEQI + 13, 0, 0, 4, 1, 64'h128, SEQI + 10, 0);
    add_v("pop_full", 0, 1, 64'h138, SEQI + 14, 0, 1, 3, 1, 64'h12C, SEQI + 11, 1);

    // Flush clears a non-empty queue.
    add_v("flush_idle", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add_v("flush_empty", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

    // Queue holds 0,4,8; flush with a concurrent push and pop.
    for (int i = 0; i < 3; i++)
      add_v($sformatf("fq%0d", i), 0, 1, 64'(4*i), LDUR + 32'(i), 0, 0,
            CW'(i+1), 1, 64'h0, LDUR, 1);
    add_v("flush_push_pop", 0, 1, 64'd12, LDUR + 3, 1, 1, 0, 0, 0, 0, 1);
    add_v("after_flush_push", 0, 1, 64'd40, 32'h11, 0, 0, 1, 1, 64'd40, 32'h11, 1);

    // Reset mid-stream with 3 entries queued.
    add_v("rq1", 0, 1, 64'd44, 32'h12, 0, 0, 2, 1, 64'd40, 32'h11, 1);
    add_v("rq2", 0, 1, 64'd48, 32'h13, 0, 0, 3, 1, 64'd40, 32'h11, 1);
    add_v("reset_mid", 1, 1, 64'h77, 32'h77, 0, 1, 0, 0, 0, 0, 1);
    add_v("push_100", 0, 1, 64'd100, 32'h22, 0, 0, 1, 1, 64'd100, 32'h22, 1);
    add_v("drain_100", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset   = vecs[i].rst;
      valid_F = vecs[i].vf;
      pc_F    = vecs[i].pc;
      instr_F = vecs[i].ins;
      flush_D = vecs[i].fl;
      ready_D = vecs[i].rd;
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check_outputs(vecs[i].name, vecs[i].e_count, vecs[i].e_valid,
                    vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_ready_f);
    end

    // ---------------- hand sequence: bypass / 1-cycle latency ----------------
    // The queue is empty here. Decode is ready and fetch offers PC 10.
    @(negedge clk);
    valid_F = 1'b1;
    pc_F    = 64'd10;
    instr_F = 32'h8B02_0020;
    ready_D = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp.same_cycle.valid_D", 64'(valid_D), 64'd1);
    check("byp.same_cycle.pc_D",    pc_D,         64'd10);
    check("byp.same_cycle.instr_D", 64'(instr_D), 64'h8B02_0020);
    @(posedge clk);
    #1;
    valid_F = 1'b0;
    #1;
    check("byp.after_edge.count",   64'(count),   64'd0);
    check("byp.after_edge.valid_D", 64'(valid_D), 64'd0);
`else
    check("byp.same_cycle.valid_D", 64'(valid_D), 64'd0);
    check("byp.same_cycle.pc_D",    pc_D,         64'd0);
    @(posedge clk);
    #1;
    valid_F = 1'b0;
    #1;
    check("byp.after_edge.valid_D", 64'(valid_D), 64'd1);
    check("byp.after_edge.pc_D",    pc_D,         64'd10);
    check("byp.after_edge.instr_D", 64'(instr_D), 64'h8B02_0020);
    check("byp.after_edge.count",   64'(count),   64'd1);
    @(posedge clk);
    #2;
    check("byp.consumed.count",     64'(count),   64'd0);
    check("byp.consumed.valid_D",   64'(valid_D), 64'd0);
`endif
    idle_inputs();

    // ---------------- hand sequence: ready_F independent of ready_D ----------
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_F = 1'b1;
      pc_F    = 64'(200 + 4*i);
      instr_F = 32'(i);
      @(posedge clk);
      #1;
      idle_inputs();
    end
    @(negedge clk);
    ready_D = 1'b1;
    #1;
    check("full.ready_F_with_ready_D", 64'(ready_F), 64'd0);
    check("full.head_pc",              pc_D,         64'd200);
    @(posedge clk);
    #1;
    ready_D = 1'b0;
    #1;
    check("full.after_pop.ready_F",    64'(ready_F), 64'd1);
    check("full.after_pop.head_pc",    pc_D,         64'd204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
